wb_bus_if: RTL and testbench

- Wishbone B3 classic master between one CPU memory port (instruction fetch or MEM stage) and the system bus.
- Sits on the requesting side of the pipeline controller.
  - Raises stallreq_o while a bus cycle is outstanding.
  - Obeys the controller's 6-bit stall vector and flush.
- Two instances are used: IF (STALL_IDX=1, stallreq_o to stallreq_from_if) and MEM (STALL_IDX=4, stallreq_o to stallreq_from_mem).

---
 rtl/wb_bus_if.sv | 147 ++++++++++++++
 tb/tb_wb_bus_if.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_if.sv
// Wishbone B3 classic master for one CPU memory port.
// Stalls the pipeline while a bus cycle is outstanding.
module wb_bus_if #(
    parameter int STALL_IDX = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic        bus_err_o,
    input  logic [31:0] wishbone_data_i,
    input  logic        wishbone_ack_i,
    output logic [31:0] wishbone_addr_o,
    output logic [31:0] wishbone_data_o,
    output logic        wishbone_we_o,
    output logic [3:0]  wishbone_sel_o,
    output logic        wishbone_stb_o,
    output logic        wishbone_cyc_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        WAIT_FOR_STALL
    } state_t;

    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [15:0] TO_LAST =
        (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'hFFFF;

    state_t      state;
    state_t      state_n;
    logic [31:0] rd_buf;
    logic [15:0] wait_cnt;
    logic        issue;
    logic        ack_ok;
    logic        abort;
    logic        drop;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, cycle events and combinational CPU-side outputs.
    always_comb begin
        state_n    = state;
        issue      = 1'b0;
        ack_ok     = 1'b0;
        abort      = 1'b0;
        stallreq_o = 1'b0;
        cpu_data_o = '0;
        unique case (state)
            IDLE: begin
                stallreq_o = cpu_ce_i & ~flush_i;
                if (cpu_ce_i && !flush_i) begin
                    issue   = 1'b1;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                stallreq_o = ~wishbone_ack_i & ~flush_i;
                if (flush_i) begin
                    state_n = IDLE;
                end else if (wishbone_ack_i) begin
                    ack_ok = 1'b1;
                    if (!wishbone_we_o) begin
                        cpu_data_o = wishbone_data_i;
                    end
                    state_n = stall_i[STALL_IDX] ?
                              WAIT_FOR_STALL : IDLE;
                end else if (TO_EN && wait_cnt == TO_LAST) begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end
            end
            WAIT_FOR_STALL: begin
                cpu_data_o = rd_buf;
                if (!stall_i[STALL_IDX] || flush_i) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Keep the controller quiet while reset is held.
        if (rst) begin
            stallreq_o = 1'b0;
            cpu_data_o = '0;
        end
    end

    assign drop = (state == BUSY) & (flush_i | ack_ok | abort);

    // Bus signals, read buffer, wait counter and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wishbone_cyc_o  <= 1'b0;
            wishbone_stb_o  <= 1'b0;
            wishbone_we_o   <= 1'b0;
            wishbone_addr_o <= '0;
            wishbone_data_o <= '0;
            wishbone_sel_o  <= '0;
            rd_buf          <= '0;
            wait_cnt        <= '0;
            bus_err_o       <= 1'b0;
        end else begin
            bus_err_o <= abort;
            if (issue) begin
                wishbone_cyc_o  <= 1'b1;
                wishbone_stb_o  <= 1'b1;
                wishbone_we_o   <= cpu_we_i;
                wishbone_addr_o <= cpu_addr_i;
                wishbone_data_o <= cpu_data_i;
                wishbone_sel_o  <= cpu_sel_i;
                wait_cnt        <= '0;
            end else if (drop) begin
                wishbone_cyc_o  <= 1'b0;
                wishbone_stb_o  <= 1'b0;
                wishbone_we_o   <= 1'b0;
                wishbone_addr_o <= '0;
                wishbone_data_o <= '0;
                wishbone_sel_o  <= '0;
            end else if (state == BUSY &&
                         wait_cnt != 16'hFFFF) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (ack_ok && !wishbone_we_o) begin
                rd_buf <= wishbone_data_i;
            end else if (abort) begin
                rd_buf <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_bus_if.sv
// Bench for wb_bus_if: directed scenarios plus random
// traffic checked against a transaction-level model.
module tb_wb_bus_if;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall_i = '0;
    logic        flush_i = 1'b0;
    logic        cpu_ce_i = 1'b0;
    logic [31:0] cpu_addr_i = '0;
    logic [31:0] cpu_data_i = '0;
    logic        cpu_we_i = 1'b0;
    logic [3:0]  cpu_sel_i = '0;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        bus_err_o;
    logic [31:0] wishbone_data_i = '0;
    logic        wishbone_ack_i = 1'b0;
    logic [31:0] wishbone_addr_o;
    logic [31:0] wishbone_data_o;
    logic        wishbone_we_o;
    logic [3:0]  wishbone_sel_o;
    logic        wishbone_stb_o;
    logic        wishbone_cyc_o;

    int vectors = 0;
    int miscompares = 0;

    wb_bus_if #(.STALL_IDX(1), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .cpu_ce_i        (cpu_ce_i),
        .cpu_addr_i      (cpu_addr_i),
        .cpu_data_i      (cpu_data_i),
        .cpu_we_i        (cpu_we_i),
        .cpu_sel_i       (cpu_sel_i),
        .cpu_data_o      (cpu_data_o),
        .stallreq_o      (stallreq_o),
        .bus_err_o       (bus_err_o),
        .wishbone_data_i (wishbone_data_i),
        .wishbone_ack_i  (wishbone_ack_i),
        .wishbone_addr_o (wishbone_addr_o),
        .wishbone_data_o (wishbone_data_o),
        .wishbone_we_o   (wishbone_we_o),
        .wishbone_sel_o  (wishbone_sel_o),
        .wishbone_stb_o  (wishbone_stb_o),
        .wishbone_cyc_o  (wishbone_cyc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    // Model: an outstanding request, a held read result,
    // the age of the request and the last read data.
    typedef struct {
        logic        busy;
        logic        hold;
        int          age;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] rbuf;
        logic        err;
    } mdl_t;

    mdl_t m = '{default: 0};
    mdl_t n = '{default: 0};

    // Compare DUT against model and work out the model's next view.
    always @(negedge clk) begin
        logic        e_stall;
        logic [31:0] e_data;
        if (rst) m = '{default: 0};
        e_stall = 1'b0;
        e_data  = '0;
        if (!rst) begin
            if (m.hold) begin
                e_data = m.rbuf;
            end else if (m.busy) begin
                e_stall = !wishbone_ack_i && !flush_i;
                if (wishbone_ack_i && !flush_i && !m.we)
                    e_data = wishbone_data_i;
            end else begin
                e_stall = cpu_ce_i && !flush_i;
            end
        end
        chk("cyc", 32'(wishbone_cyc_o), 32'(m.busy));
        chk("stb", 32'(wishbone_stb_o), 32'(m.busy));
        chk("bus_err", 32'(bus_err_o), 32'(m.err));
        chk("stallreq", 32'(stallreq_o), 32'(e_stall));
        chk("cpu_data", cpu_data_o, e_data);
        if (m.busy || rst) begin
            chk("addr", wishbone_addr_o, m.addr);
            chk("wdata", wishbone_data_o, m.wd);
            chk("we", 32'(wishbone_we_o), 32'(m.we));
            chk("sel", 32'(wishbone_sel_o), 32'(m.sel));
        end
        n = m;
        n.err = 1'b0;
        if (!rst) begin
            if (m.hold) begin
                if (!stall_i[1] || flush_i) n.hold = 1'b0;
            end else if (m.busy) begin
                if (flush_i) begin
                    n.busy = 1'b0;
                end else if (wishbone_ack_i) begin
                    n.busy = 1'b0;
                    if (!m.we) n.rbuf = wishbone_data_i;
                    n.hold = stall_i[1];
                end else if (m.age == TO - 1) begin
                    n.busy = 1'b0;
                    n.err  = 1'b1;
                    n.rbuf = '0;
                end else begin
                    n.age = m.age + 1;
                end
            end else if (cpu_ce_i && !flush_i) begin
                n.busy = 1'b1;
                n.age  = 0;
                n.addr = cpu_addr_i;
                n.wd   = cpu_data_i;
                n.we   = cpu_we_i;
                n.sel  = cpu_sel_i;
            end
        end
    end

    // Advance the model on each edge; reset wins.
    always @(posedge clk) begin
        if (rst) m = '{default: 0};
        else m = n;
    end

    task automatic drv(input logic ce, input logic we,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [3:0] s,
                       input logic ack,
                       input logic [31:0] rd,
                       input logic [5:0] st,
                       input logic fl);
        @(posedge clk);
        #1;
        cpu_ce_i        = ce;
        cpu_we_i        = we;
        cpu_addr_i      = a;
        cpu_data_i      = d;
        cpu_sel_i       = s;
        wishbone_ack_i  = ack;
        wishbone_data_i = rd;
        stall_i         = st;
        flush_i         = fl;
        @(negedge clk);
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_cyc", 32'(wishbone_cyc_o), 0);
        chk("rst_addr", wishbone_addr_o, 0);
        chk("rst_stallreq", 32'(stallreq_o), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Read 0x104, ack on third BUSY cycle.
        drv(1, 0, 32'h104, 0, 4'hF, 0, 0, 0, 0);
        chk("rd_req_stall", 32'(stallreq_o), 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rd_cyc", 32'(wishbone_cyc_o), 1);
        chk("rd_addr", wishbone_addr_o, 32'h104);
        chk("rd_busy_stall", 32'(stallreq_o), 1);
        idle();
        drv(0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
        chk("rd_ack_data", cpu_data_o, 32'hDEADBEEF);
        chk("rd_ack_stall", 32'(stallreq_o), 0);
        idle();
        chk("rd_done_cyc", 32'(wishbone_cyc_o), 0);
        chk("rd_done_data", cpu_data_o, 0);

        // Write 0x11223344 to 0x80, lanes 0011.
        drv(1, 1, 32'h80, 32'h11223344, 4'b0011,
            0, 0, 0, 0);
        idle();
        chk("wr_we", 32'(wishbone_we_o), 1);
        chk("wr_data", wishbone_data_o, 32'h11223344);
        chk("wr_sel", 32'(wishbone_sel_o), 32'h3);
        drv(0, 0, 0, 0, 0, 1, 32'h99999999, 0, 0);
        chk("wr_ack_data", cpu_data_o, 0);
        idle();
        chk("wr_done_cyc", 32'(wishbone_cyc_o), 0);

        // Read acked under stall, held for several cycles.
        drv(1, 0, 32'h200, 0, 4'hF, 0, 0, 0, 0);
        idle();
        drv(0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 6'b001111, 0);
        chk("st_ack_data", cpu_data_o, 32'hCAFEF00D);
        for (int i = 0; i < 4; i++) begin
            drv(1, 0, 32'h204, 0, 4'hF, 0, 0, 6'b001111, 0);
            chk("st_hold_data", cpu_data_o, 32'hCAFEF00D);
            chk("st_hold_stall", 32'(stallreq_o), 0);
            chk("st_hold_cyc", 32'(wishbone_cyc_o), 0);
        end
        idle();
        chk("st_last_data", cpu_data_o, 32'hCAFEF00D);
        idle();
        chk("st_after_data", cpu_data_o, 0);

        // Flush with simultaneous ack in second BUSY cycle.
        drv(1, 0, 32'h300, 0, 4'hF, 0, 0, 0, 0);
        idle();
        drv(0, 0, 0, 0, 0, 1, 32'h55555555, 0, 1);
        chk("fl_stall", 32'(stallreq_o), 0);
        chk("fl_data", cpu_data_o, 0);
        idle();
        chk("fl_cyc", 32'(wishbone_cyc_o), 0);
        chk("fl_stb", 32'(wishbone_stb_o), 0);

        // Timeout after four BUSY cycles.
        drv(1, 0, 32'h400, 0, 4'hF, 0, 0, 0, 0);
        repeat (4) idle();
        chk("to_cyc_last", 32'(wishbone_cyc_o), 1);
        idle();
        chk("to_cyc", 32'(wishbone_cyc_o), 0);
        chk("to_err", 32'(bus_err_o), 1);
        chk("to_stall", 32'(stallreq_o), 0);
        idle();
        chk("to_err_off", 32'(bus_err_o), 0);

        // Asynchronous reset mid-BUSY.
        drv(1, 0, 32'h500, 0, 4'hF, 0, 0, 0, 0);
        drv(1, 0, 32'h500, 0, 4'hF, 0, 0, 0, 0);
        chk("rs_cyc_pre", 32'(wishbone_cyc_o), 1);
        #2 rst = 1'b1;
        #1;
        chk("rs_cyc", 32'(wishbone_cyc_o), 0);
        chk("rs_stb", 32'(wishbone_stb_o), 0);
        chk("rs_stall", 32'(stallreq_o), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rs_req", 32'(stallreq_o), 1);
        idle();
        chk("rs_new_cyc", 32'(wishbone_cyc_o), 1);
        chk("rs_new_addr", wishbone_addr_o, 32'h500);
        idle();
        idle();

        // Random traffic, including spurious acks and resets.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            rst             = ($urandom_range(0, 299) == 0);
            cpu_ce_i        = ($urandom_range(0, 2) != 0);
            cpu_we_i        = 1'($urandom_range(0, 1));
            cpu_addr_i      = $urandom;
            cpu_data_i      = $urandom;
            cpu_sel_i       = 4'($urandom_range(0, 15));
            wishbone_ack_i  = ($urandom_range(0, 2) == 0);
            wishbone_data_i = $urandom;
            stall_i         = 6'($urandom_range(0, 63));
            stall_i[1]      = ($urandom_range(0, 2) == 0);
            flush_i         = ($urandom_range(0, 11) == 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
